// File: rtl/alu8_pkg.sv
// Shared opcode, FSM state and command-record definitions for the ALU issue stage.
package alu8_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int unsigned CMD_W = 18;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
  } cmd_t;

endpackage

// File: rtl/alu8_cmd_fifo.sv
// Synchronous command FIFO, DEPTH x CMD_W, with extra-MSB pointers for full/empty.
module alu8_cmd_fifo
  import alu8_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_wdata,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; reset empties the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write; contents are don't-care while the slot is unused.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/alu8_issue_ctrl.sv
// Issue stage for the 8-bit ALU: queues commands, drives registered operands,
// captures the result one cycle later and presents it on a valid/ready port.
module alu8_issue_ctrl
  import alu8_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter logic [15:0] DZ_FILL = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [1:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [1:0]  alu_s,
  input  logic [15:0] alu_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [1:0]  res_op,
  output logic        res_dz,
  output logic        res_neg,
  output logic        busy
);

  state_t           r_state;
  state_t           w_next;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_capture;
  logic             w_release;
  logic             w_dz;
  logic             w_neg;
  logic [CMD_W-1:0] w_head_bits;
  cmd_t             w_head;
  cmd_t             w_wcmd;

  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [1:0]  r_alu_s;
  logic        r_res_valid;
  logic [15:0] r_res_data;
  logic [1:0]  r_res_op;
  logic        r_res_dz;
  logic        r_res_neg;

  assign cmd_ready = rst_n & ~w_full;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_wcmd    = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign w_head    = cmd_t'(w_head_bits);

  alu8_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wcmd),
    .i_pop   (w_pop),
    .o_rdata (w_head_bits),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Operands stay in alu_* through EXEC, so flags are derived from them.
  assign w_dz  = (r_alu_s == OP_DIV) && (r_alu_b == '0);
  assign w_neg = (r_alu_s == OP_SUB) && (r_alu_a < r_alu_b);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (!w_empty) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_HOLD;
      ST_HOLD: if (res_ready) w_next = w_empty ? ST_IDLE : ST_EXEC;
      default: w_next = ST_IDLE;
    endcase
  end

  // Per-state control strobes: pop, capture, release.
  always_comb begin
    w_pop     = 1'b0;
    w_capture = 1'b0;
    w_release = 1'b0;
    case (r_state)
      ST_IDLE: w_pop = ~w_empty;
      ST_EXEC: w_capture = 1'b1;
      ST_HOLD: begin
        w_release = res_ready;
        w_pop     = res_ready & ~w_empty;
      end
      default: ;
    endcase
  end

  // Operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_op    <= '0;
      r_res_dz    <= 1'b0;
      r_res_neg   <= 1'b0;
    end else begin
      if (w_pop) begin
        r_alu_a <= w_head.a;
        r_alu_b <= w_head.b;
        r_alu_s <= w_head.op;
      end
      if (w_capture) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_dz ? DZ_FILL : alu_y;
        r_res_op    <= r_alu_s;
        r_res_dz    <= w_dz;
        r_res_neg   <= w_neg;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign res_dz    = r_res_dz;
  assign res_neg   = r_res_neg;
  assign busy      = ~w_empty | (r_state != ST_IDLE);

endmodule
